// File: rtl/mips_soc_pkg.sv
// Shared MIPS SoC definitions: text-segment defaults, word-index width and
// the fetch sequencer state encoding.
package mips_soc_pkg;

  localparam int unsigned WORD_IDX_W     = 10;
  localparam logic [31:0] DEF_TEXT_BASE  = 32'h0040_0000;
  localparam logic [31:0] DEF_TEXT_LIMIT = 32'h0040_0FFF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_VALID = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_range_check.sv
// Maps a virtual PC onto the instruction-memory word index and flags PCs
// outside the text segment or not word aligned. Purely combinational.
module pc_range_check
  import mips_soc_pkg::*;
#(
  parameter logic [31:0] BASE  = DEF_TEXT_BASE,
  parameter logic [31:0] LIMIT = DEF_TEXT_LIMIT
) (
  input  logic [31:0]           pc,
  output logic [WORD_IDX_W-1:0] word_idx,
  output logic                  invalid
);

  assign word_idx = WORD_IDX_W'((pc - BASE) >> 2);
  assign invalid  = (pc < BASE) || (pc > LIMIT) || (pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: FETCH -> VALID -> FETCH loop with redirects and
// an invalid-PC trap. Define FETCH_PERF_COUNTER_EN to add the fetch_count port.
module fetch_sequencer
  import mips_soc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_TEXT_BASE,
  parameter logic [31:0] TEXT_LIMIT = DEF_TEXT_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [WORD_IDX_W-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  fault,
  output logic [31:0]           fault_pc,
  input  logic                  fault_clear
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0]           fetch_count
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_pc_q, pend_pc_d;

  logic [31:0]           nxt_pc;
  logic                  nxt_bad;
  logic                  cur_bad;
  logic [WORD_IDX_W-1:0] nxt_idx;

  pc_range_check #(.BASE(RESET_PC), .LIMIT(TEXT_LIMIT)) u_cur_chk (
    .pc       (pc_q),
    .word_idx (imem_addr),
    .invalid  (cur_bad)
  );

  pc_range_check #(.BASE(RESET_PC), .LIMIT(TEXT_LIMIT)) u_nxt_chk (
    .pc       (nxt_pc),
    .word_idx (nxt_idx),
    .invalid  (nxt_bad)
  );

  // Candidate PC: in VALID the handshake target, in FETCH the redirect target
  // (a same-cycle redirect overrides an older pending one).
  always_comb begin
    if (state_q == ST_VALID) nxt_pc = redirect_valid ? redirect_pc : pc_q + 32'd4;
    else                     nxt_pc = redirect_valid ? redirect_pc : pend_pc_q;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_pc_d = fault_pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    case (state_q)
      ST_FETCH: begin
        if (cur_bad) begin
          state_d    = ST_FAULT;
          fault_pc_d = pc_q;
        end else if (imem_ack) begin
          if (redirect_valid || pend_q) begin
            // Returned word belongs to the abandoned path; drop it.
            pend_d = 1'b0;
            pc_d   = nxt_pc;
            if (nxt_bad) begin
              state_d    = ST_FAULT;
              fault_pc_d = nxt_pc;
            end
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = ST_VALID;
          end
        end else if (redirect_valid) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
      end
      ST_VALID: begin
        if (instr_ready) begin
          pc_d = nxt_pc;
          if (nxt_bad) begin
            state_d    = ST_FAULT;
            fault_pc_d = nxt_pc;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FAULT: begin
        if (fault_clear) begin
          pc_d    = RESET_PC;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      fault_pc_q <= '0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      fault_pc_q <= fault_pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  // Outputs read as reset values for the whole time rst is high.
  assign imem_req    = !rst && (state_q == ST_FETCH);
  assign instr_valid = !rst && (state_q == ST_VALID);
  assign fault       = !rst && (state_q == ST_FAULT);
  assign instr       = rst ? '0 : instr_q;
  assign instr_pc    = rst ? '0 : instr_pc_q;
  assign fault_pc    = rst ? '0 : fault_pc_q;

`ifdef FETCH_PERF_COUNTER_EN
  logic        hs;
  logic [31:0] fetch_count_q, fetch_count_d;

  assign hs            = (state_q == ST_VALID) && instr_ready;
  assign fetch_count_d = fetch_count_q + {31'd0, hs};
  assign fetch_count   = fetch_count_q;

  always_ff @(posedge clk) begin
    if (rst) fetch_count_q <= '0;
    else     fetch_count_q <= fetch_count_d;
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] LIMIT  = 32'h0040_0FFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic        fault_clear;
`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] fetch_count;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(RST_PC), .TEXT_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fault_clear    (fault_clear)
`ifdef FETCH_PERF_COUNTER_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: where the fetch stream is (awaiting memory, holding an
  // instruction for the decoder, or trapped) and the PC it is working on.
  bit          m_busy, m_hold, m_trap;
  logic [31:0] m_pc, m_instr, m_ipc, m_fpc, m_tgt;
  bit          m_tgt_set;
  int unsigned m_cnt;

  function automatic bit pc_ok(input logic [31:0] p);
    return (p >= RST_PC) && (p <= LIMIT) && (p % 4 == 0);
  endfunction

  function automatic logic [9:0] widx(input logic [31:0] p);
    logic [31:0] w;
    w = (p - RST_PC) / 4;
    return w[9:0];
  endfunction

  task automatic m_reset();
    m_busy = 1; m_hold = 0; m_trap = 0;
    m_pc = RST_PC; m_instr = 0; m_ipc = 0; m_fpc = 0;
    m_tgt_set = 0; m_tgt = 0; m_cnt = 0;
  endtask

  task automatic m_goto(input logic [31:0] p);
    m_pc = p; m_hold = 0;
    if (pc_ok(p)) m_busy = 1;
    else begin m_busy = 0; m_trap = 1; m_fpc = p; end
  endtask

  task automatic m_step(input bit r, input bit ack, input logic [31:0] d, input bit rdy,
                        input bit rv, input logic [31:0] rp, input bit fc);
    if (r) m_reset();
    else if (m_busy) begin
      if (ack && (rv || m_tgt_set)) begin
        m_tgt_set = 0;
        m_goto(rv ? rp : m_tgt);
      end else if (ack) begin
        m_instr = d; m_ipc = m_pc; m_busy = 0; m_hold = 1;
      end else if (rv) begin
        m_tgt_set = 1; m_tgt = rp;
      end
    end else if (m_hold) begin
      if (rdy) begin
        m_cnt++;
        m_goto(rv ? rp : m_pc + 32'd4);
      end
    end else if (m_trap && fc) begin
      m_trap = 0; m_busy = 1; m_pc = RST_PC;
    end
  endtask

  task automatic m_check();
    chk("imem_req", {31'd0, imem_req}, {31'd0, !rst && m_busy});
    if (!rst && m_busy) chk("imem_addr", {22'd0, imem_addr}, {22'd0, widx(m_pc)});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, !rst && m_hold});
    chk("instr", instr, rst ? 32'd0 : m_instr);
    chk("instr_pc", instr_pc, rst ? 32'd0 : m_ipc);
    chk("fault", {31'd0, fault}, {31'd0, !rst && m_trap});
    chk("fault_pc", fault_pc, rst ? 32'd0 : m_fpc);
`ifdef FETCH_PERF_COUNTER_EN
    chk("fetch_count", fetch_count, m_cnt);
`endif
  endtask

  // Apply one cycle of inputs: check outputs mid-cycle, then clock DUT and model.
  task automatic cyc(input bit ack, input logic [31:0] d, input bit rdy, input bit rv,
                     input logic [31:0] rp, input bit fc, input bit r);
    rst = r; imem_ack = ack; imem_rdata = d; instr_ready = rdy;
    redirect_valid = rv; redirect_pc = rp; fault_clear = fc;
    #1;
    m_check();
    @(posedge clk);
    m_step(r, ack, d, rdy, rv, rp, fc);
    #1;
  endtask

  logic [31:0] rp;

  initial begin
    rst = 1; imem_ack = 0; imem_rdata = 0; instr_ready = 0;
    redirect_valid = 0; redirect_pc = 0; fault_clear = 0;
    repeat (2) @(posedge clk);
    m_reset();
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);

    // Sequential fetch, ack every second cycle, decoder always ready.
    rst = 0; #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", {22'd0, imem_addr}, i);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(1, 32'hA000_0000 + i, 1, 0, 0, 0, 0);
      chk("seq_ipc", instr_pc, RST_PC + 4 * i);
      chk("seq_instr", instr, 32'hA000_0000 + i);
      cyc(0, 0, 1, 0, 0, 0, 0);
    end

    // Redirect with handshake.
    cyc(1, 32'h1111_1111, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h0040_0100, 0, 0);
    chk("redir_addr", {22'd0, imem_addr}, 32'h040);
    // Redirect during FETCH: in-flight data dropped.
    cyc(0, 0, 0, 1, 32'h0040_0200, 0, 0);
    cyc(1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0);
    chk("drop_valid", {31'd0, instr_valid}, 32'd0);
    chk("drop_addr", {22'd0, imem_addr}, 32'h080);

    // Run off the end of the text segment.
    cyc(1, 32'h2222_2222, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h0040_0FFC, 0, 0);
    chk("end_addr", {22'd0, imem_addr}, 32'h3FF);
    cyc(1, 32'h3333_3333, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("end_fault", {31'd0, fault}, 32'd1);
    chk("end_fault_pc", fault_pc, 32'h0040_1000);
    chk("end_req", {31'd0, imem_req}, 32'd0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    chk("stay_fault", {31'd0, fault}, 32'd1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("clr_addr", {22'd0, imem_addr}, 32'd0);
    chk("clr_req", {31'd0, imem_req}, 32'd1);

    // Misaligned redirect target.
    cyc(1, 32'h4444_4444, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h0040_0002, 0, 0);
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h0040_0002);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // Reset mid-FETCH with a late ack arriving during reset.
    cyc(0, 0, 0, 1, 32'h0040_0300, 0, 0);
    cyc(1, 32'h5555_5555, 0, 0, 0, 0, 1);
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    chk("mrst_ipc", instr_pc, 32'd0);
    chk("mrst_fpc", fault_pc, 32'd0);
    chk("mrst_addr", {22'd0, imem_addr}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("mrst_req2", {31'd0, imem_req}, 32'd1);

`ifdef FETCH_PERF_COUNTER_EN
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, i, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
    end
    chk("cnt5", fetch_count, 32'd5);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("cnt_rst", fetch_count, 32'd0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 9))
        0:       rp = $urandom();
        1:       rp = RST_PC + 4 * $urandom_range(0, 1023) + $urandom_range(1, 3);
        2:       rp = 32'h0040_0FFC;
        default: rp = RST_PC + 4 * $urandom_range(0, 1023);
      endcase
      cyc($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 9) < 6,
          $urandom_range(0, 4) == 0, rp, $urandom_range(0, 2) == 0,
          $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
